// File: rtl/out_buff_ctrl_pkg.sv
// Shared types and helpers for the output buffer controller.
//   state_e : layer sequencer states
//   clogb2  : ceil(log2(value)), used to size bank addresses and counters
package out_buff_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StTail,
    StDone
  } state_e;

  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((32'd1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/out_buff_port_arb.sv
// Single-port bank arbiter between array writes and drain reads.
// Writes win by default; a read that keeps losing is forced through once it
// has been deferred MAX_DEFER consecutive times (MAX_DEFER must be >= 1).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : clears the defer counter (new layer)
//   wr_req    : write request
//   rd_req    : read request
//   wr_gnt    : write granted
//   rd_gnt    : read granted
//   force_rd  : read wins this cycle because of the starvation guard
module out_buff_port_arb
  import out_buff_ctrl_pkg::*;
#(
  parameter int unsigned MAX_DEFER = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic wr_req,
  input  logic rd_req,
  output logic wr_gnt,
  output logic rd_gnt,
  output logic force_rd
);

  localparam int unsigned DeferW = clogb2(MAX_DEFER + 1);
  localparam logic [DeferW-1:0] DeferMax = DeferW'(MAX_DEFER);

  logic [DeferW-1:0] defer_q;

  always_comb begin
    force_rd = rd_req && (defer_q == DeferMax);
    wr_gnt   = wr_req && !force_rd;
    rd_gnt   = rd_req && (!wr_req || force_rd);
  end

  // Never exceeds DeferMax: at that value any pending read is granted.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      defer_q <= '0;
    end else if (rd_gnt) begin
      defer_q <= '0;
    end else if (rd_req) begin
      defer_q <= defer_q + DeferW'(1);
    end
  end

endmodule

// File: rtl/out_buff_ctrl.sv
// Per-layer sequencer and port arbiter for the even/odd output buffer banks.
// Accepts array result beats, writes them into the banks, and streams them out
// to the drain consumer with valid/ready. Banks are single-port, so each cycle
// either a write or a read is issued (never both).
// Optional build macro OUT_BUFF_CTRL_PERF_CNT_EN adds saturating 32-bit
// perf counters (stall, deferred-read and full cycles).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   layer_start, layer_len   : start pulse and beat count (sampled when idle)
//   busy, layer_done         : layer in progress / completion pulse
//   arr_valid, arr_stall     : array beat handshake (ready = !arr_stall)
//   wEn_*_AH, wAddr_*        : bank write enables / addresses (per row)
//   rEn_*_AH, rAddr_*        : bank read enables / addresses (per row)
//   drain_valid, drain_ready : drain handshake on the bank outputs
//   perf_*_cycles            : perf counters (macro builds only)
module out_buff_ctrl
  import out_buff_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PE_ROW = 4,
  parameter int unsigned NB_DATA    = 8192,
  parameter int unsigned ADDR_WIDTH = clogb2(NB_DATA),
  parameter int unsigned MAX_DEFER  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           layer_start,
  input  logic [ADDR_WIDTH:0]            layer_len,
  output logic                           busy,
  output logic                           layer_done,
  input  logic                           arr_valid,
  output logic                           arr_stall,
  output logic [NUM_PE_ROW-1:0]          wEn_even_AH,
  output logic [NUM_PE_ROW-1:0]          wEn_odd_AH,
  output logic [NUM_PE_ROW*ADDR_WIDTH-1:0] wAddr_even,
  output logic [NUM_PE_ROW*ADDR_WIDTH-1:0] wAddr_odd,
  output logic [NUM_PE_ROW-1:0]          rEn_even_AH,
  output logic [NUM_PE_ROW-1:0]          rEn_odd_AH,
  output logic [NUM_PE_ROW*ADDR_WIDTH-1:0] rAddr_even,
  output logic [NUM_PE_ROW*ADDR_WIDTH-1:0] rAddr_odd,
  output logic                           drain_valid,
  input  logic                           drain_ready
`ifdef OUT_BUFF_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]                    perf_stall_cycles,
  output logic [31:0]                    perf_defer_cycles,
  output logic [31:0]                    perf_full_cycles
`endif
);

  localparam int unsigned PtrW = ADDR_WIDTH + 1;
  localparam logic [PtrW-1:0] FullOcc = PtrW'(NB_DATA);

  state_e          state_q;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW-1:0] wr_cnt_q, rd_cnt_q;
  logic [PtrW-1:0] len_q;
  logic            drain_valid_q, busy_q, layer_done_q;

  logic [PtrW-1:0] occupancy;
  logic            full, empty, run, active, start_ok;
  logic            wr_req, rd_req, wr_gnt, rd_gnt, force_rd;

  // Occupancy uses registered pointers, so a beat written this cycle is only
  // readable from the next cycle on.
  always_comb begin
    occupancy = wr_ptr_q - rd_ptr_q;
    full      = (occupancy == FullOcc);
    empty     = (occupancy == '0);
    run       = (state_q == StRun);
    active    = run || (state_q == StTail);
    start_ok  = (state_q == StIdle) && layer_start;
    wr_req    = run && arr_valid && !full;
    // Only read when the output slot is free or being emptied this cycle.
    rd_req    = active && !empty && (!drain_valid_q || drain_ready);
  end

  out_buff_port_arb #(
    .MAX_DEFER (MAX_DEFER)
  ) u_port_arb (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_ok),
    .wr_req   (wr_req),
    .rd_req   (rd_req),
    .wr_gnt   (wr_gnt),
    .rd_gnt   (rd_gnt),
    .force_rd (force_rd)
  );

  always_comb begin
    arr_stall   = run && (full || force_rd);
    wEn_even_AH = {NUM_PE_ROW{wr_gnt}};
    wEn_odd_AH  = {NUM_PE_ROW{wr_gnt}};
    rEn_even_AH = {NUM_PE_ROW{rd_gnt}};
    rEn_odd_AH  = {NUM_PE_ROW{rd_gnt}};
    wAddr_even  = {NUM_PE_ROW{wr_ptr_q[ADDR_WIDTH-1:0]}};
    wAddr_odd   = {NUM_PE_ROW{wr_ptr_q[ADDR_WIDTH-1:0]}};
    rAddr_even  = {NUM_PE_ROW{rd_ptr_q[ADDR_WIDTH-1:0]}};
    rAddr_odd   = {NUM_PE_ROW{rd_ptr_q[ADDR_WIDTH-1:0]}};
    drain_valid = drain_valid_q;
    busy        = busy_q;
    layer_done  = layer_done_q;
  end

  // Sequencer, pointers and registered status outputs. layer_done is raised
  // on the exit edge of StDone, the same edge that drops busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      len_q         <= '0;
      drain_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      layer_done_q  <= 1'b0;
    end else begin
      layer_done_q <= 1'b0;
      if (wr_gnt) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
        wr_cnt_q <= wr_cnt_q + PtrW'(1);
      end
      if (rd_gnt) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
        rd_cnt_q <= rd_cnt_q + PtrW'(1);
      end
      // One-cycle read latency; bank outputs hold until the beat is taken.
      if (rd_gnt) begin
        drain_valid_q <= 1'b1;
      end else if (drain_ready) begin
        drain_valid_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (layer_start) begin
            // The previous layer left the banks empty, so restart at 0.
            len_q    <= layer_len;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= (layer_len == '0) ? StDone : StRun;
          end
        end
        StRun: begin
          if (wr_gnt && (wr_cnt_q + PtrW'(1) == len_q)) begin
            state_q <= StTail;
          end
        end
        StTail: begin
          if ((rd_cnt_q == len_q) && drain_valid_q && drain_ready) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q      <= StIdle;
          busy_q       <= 1'b0;
          layer_done_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef OUT_BUFF_CTRL_PERF_CNT_EN
  logic read_deferred;
  always_comb read_deferred = rd_req && !rd_gnt;

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      perf_stall_cycles <= '0;
      perf_defer_cycles <= '0;
      perf_full_cycles  <= '0;
    end else begin
      if (arr_stall && (perf_stall_cycles != '1)) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
      if (read_deferred && (perf_defer_cycles != '1)) begin
        perf_defer_cycles <= perf_defer_cycles + 32'd1;
      end
      if (active && full && (perf_full_cycles != '1)) begin
        perf_full_cycles <= perf_full_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_out_buff_ctrl.sv
// Directed bench for out_buff_ctrl (NB_DATA = 8, 4 PE rows, MAX_DEFER = 4).
// Each row drives {layer_start, arr_valid, drain_ready} for one cycle and
// holds the expected {busy, layer_done, arr_stall, drain_valid, wEn, rEn,
// wAddr, rAddr}; enables/addresses are expanded to the full replicated buses.
// Build with OUT_BUFF_CTRL_PERF_CNT_EN to also check the perf counters.
module tb_out_buff_ctrl;

  localparam int unsigned N     = 4;
  localparam int unsigned AW    = 3;
  localparam int unsigned OBS_W = 4 + 4 * N + 4 * N * AW;

  logic            clk = 1'b0;
  logic            rst;
  logic            layer_start;
  logic [AW:0]     layer_len;
  logic            busy, layer_done;
  logic            arr_valid, arr_stall;
  logic [N-1:0]    wEn_even_AH, wEn_odd_AH, rEn_even_AH, rEn_odd_AH;
  logic [N*AW-1:0] wAddr_even, wAddr_odd, rAddr_even, rAddr_odd;
  logic            drain_valid, drain_ready;
`ifdef OUT_BUFF_CTRL_PERF_CNT_EN
  logic [31:0]     perf_stall_cycles, perf_defer_cycles, perf_full_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  out_buff_ctrl #(
    .NUM_PE_ROW (N),
    .NB_DATA    (8),
    .MAX_DEFER  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .layer_start (layer_start),
    .layer_len   (layer_len),
    .busy        (busy),
    .layer_done  (layer_done),
    .arr_valid   (arr_valid),
    .arr_stall   (arr_stall),
    .wEn_even_AH (wEn_even_AH),
    .wEn_odd_AH  (wEn_odd_AH),
    .wAddr_even  (wAddr_even),
    .wAddr_odd   (wAddr_odd),
    .rEn_even_AH (rEn_even_AH),
    .rEn_odd_AH  (rEn_odd_AH),
    .rAddr_even  (rAddr_even),
    .rAddr_odd   (rAddr_odd),
    .drain_valid (drain_valid),
    .drain_ready (drain_ready)
`ifdef OUT_BUFF_CTRL_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_defer_cycles (perf_defer_cycles),
    .perf_full_cycles  (perf_full_cycles)
`endif
  );

  logic [OBS_W-1:0] obs;
  assign obs = {busy, layer_done, arr_stall, drain_valid,
                wEn_even_AH, wEn_odd_AH, rEn_even_AH, rEn_odd_AH,
                wAddr_even, wAddr_odd, rAddr_even, rAddr_odd};

  // e = {busy, done, stall, dv, we, re, wa[2:0], ra[2:0]}
  function automatic logic [OBS_W-1:0] expect_of(input logic [11:0] e);
    logic [AW-1:0] wa, ra;
    wa = e[5:3];
    ra = e[2:0];
    return {e[11], e[10], e[9], e[8],
            {N{e[7]}}, {N{e[7]}}, {N{e[6]}}, {N{e[6]}},
            {N{wa}}, {N{wa}}, {N{ra}}, {N{ra}}};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    layer_start = 1'b0;
    layer_len = '0;
    arr_valid = 1'b0;
    drain_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL reset outputs: got %h, want 0", obs);
    end
`ifdef OUT_BUFF_CTRL_PERF_CNT_EN
    n_cmp++;
    if ({perf_stall_cycles, perf_defer_cycles, perf_full_cycles} !== 96'd0) begin
      n_err++;
      $display("FAIL reset perf: got %h %h %h, want 0", perf_stall_cycles,
               perf_defer_cycles, perf_full_cycles);
    end
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // layer_len = 3: writes 0,1,2 then reads in write-free cycles.
  task automatic test_basic();
    logic [14:0] rows [11];
    rows = '{15'b101_000000_000_000, 15'b011_100010_000_000, 15'b011_100010_001_000,
             15'b011_100010_010_000, 15'b001_100001_011_000, 15'b001_100101_011_001,
             15'b001_100101_011_010, 15'b001_100100_011_011, 15'b001_100000_011_011,
             15'b001_010000_011_011, 15'b001_000000_011_011};
    layer_len = 4'd3;
    for (int i = 0; i < 11; i++) begin
      {layer_start, arr_valid, drain_ready} = rows[i][14:12];
      @(negedge clk);
      n_cmp++;
      if (obs !== expect_of(rows[i][11:0])) begin
        n_err++;
        $display("FAIL basic cycle %0d: got %h, want %h", i, obs, expect_of(rows[i][11:0]));
      end
      @(posedge clk);
      #1;
    end
    layer_start = 1'b0;
  endtask

  // Read deferred 4 cycles, forced on the 5th; then a reset mid-RUN.
  task automatic test_starvation();
    logic [14:0] rows [8];
    rows = '{15'b111_000000_011_011, 15'b011_100010_000_000, 15'b011_100010_001_000,
             15'b011_100010_010_000, 15'b011_100010_011_000, 15'b011_100010_100_000,
             15'b011_101001_101_000, 15'b011_100110_101_001};
    layer_len = 4'd8;
    for (int i = 0; i < 8; i++) begin
      {layer_start, arr_valid, drain_ready} = rows[i][14:12];
      @(negedge clk);
      n_cmp++;
      if (obs !== expect_of(rows[i][11:0])) begin
        n_err++;
        $display("FAIL starve cycle %0d: got %h, want %h", i, obs, expect_of(rows[i][11:0]));
      end
`ifdef OUT_BUFF_CTRL_PERF_CNT_EN
      if (i == 7) begin
        n_cmp++;
        if (perf_defer_cycles !== 32'd4) begin
          n_err++;
          $display("FAIL perf_defer: got %0d, want 4", perf_defer_cycles);
        end
        n_cmp++;
        if (perf_stall_cycles !== 32'd1) begin
          n_err++;
          $display("FAIL perf_stall: got %0d, want 1", perf_stall_cycles);
        end
        n_cmp++;
        if (perf_full_cycles !== 32'd0) begin
          n_err++;
          $display("FAIL perf_full: got %0d, want 0", perf_full_cycles);
        end
      end
`endif
      @(posedge clk);
      #1;
    end
    layer_start = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== '0) begin
        n_err++;
        $display("FAIL mid-run reset cycle %0d: got %h, want 0", i, obs);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // NB_DATA = 8, drain blocked: fill, stall on full, wrap, drain 12 in order.
  task automatic test_full_wrap();
    logic [14:0] rows [30];
    rows = '{15'b110_000000_000_000, 15'b010_100010_000_000, 15'b010_100010_001_000,
             15'b010_100010_010_000, 15'b010_100010_011_000, 15'b010_100010_100_000,
             15'b010_101001_101_000, 15'b010_100110_101_001, 15'b010_100110_110_001,
             15'b010_100110_111_001, 15'b010_100110_000_001, 15'b010_101100_001_001,
             15'b010_101100_001_001, 15'b011_101101_001_001, 15'b011_100110_001_010,
             15'b011_101001_010_010, 15'b011_100110_010_011, 15'b011_101001_011_011,
             15'b011_100110_011_100, 15'b011_100001_100_100, 15'b011_100101_100_101,
             15'b011_100101_100_110, 15'b011_100101_100_111, 15'b011_100101_100_000,
             15'b011_100101_100_001, 15'b011_100101_100_010, 15'b011_100101_100_011,
             15'b011_100100_100_100, 15'b011_100000_100_100, 15'b011_010000_100_100};
    layer_len = 4'd12;
    for (int i = 0; i < 30; i++) begin
      {layer_start, arr_valid, drain_ready} = rows[i][14:12];
      @(negedge clk);
      n_cmp++;
      if (obs !== expect_of(rows[i][11:0])) begin
        n_err++;
        $display("FAIL full_wrap cycle %0d: got %h, want %h", i, obs, expect_of(rows[i][11:0]));
      end
      @(posedge clk);
      #1;
    end
    layer_start = 1'b0;
  endtask

  // drain_ready 1,0,0,1 while beats are pending; start in RUN is ignored.
  task automatic test_backpressure();
    logic [14:0] rows [12];
    rows = '{15'b101_000000_100_100, 15'b011_100010_000_000, 15'b111_100010_001_000,
             15'b011_100010_010_000, 15'b001_100001_011_000, 15'b001_100101_011_001,
             15'b000_100100_011_010, 15'b000_100100_011_010, 15'b001_100101_011_010,
             15'b001_100100_011_011, 15'b001_100000_011_011, 15'b001_010000_011_011};
    layer_len = 4'd3;
    for (int i = 0; i < 12; i++) begin
      {layer_start, arr_valid, drain_ready} = rows[i][14:12];
      @(negedge clk);
      n_cmp++;
      if (obs !== expect_of(rows[i][11:0])) begin
        n_err++;
        $display("FAIL backpressure cycle %0d: got %h, want %h", i, obs,
                 expect_of(rows[i][11:0]));
      end
      @(posedge clk);
      #1;
    end
    layer_start = 1'b0;
  endtask

  // layer_len = 0 goes straight to done; a start while busy is ignored.
  task automatic test_edge_cases();
    logic [14:0] rows [4];
    rows = '{15'b111_000000_011_011, 15'b111_100000_000_000, 15'b010_010000_000_000,
             15'b010_000000_000_000};
    layer_len = 4'd0;
    for (int i = 0; i < 4; i++) begin
      {layer_start, arr_valid, drain_ready} = rows[i][14:12];
      if (i == 1) layer_len = 4'd5;
      @(negedge clk);
      n_cmp++;
      if (obs !== expect_of(rows[i][11:0])) begin
        n_err++;
        $display("FAIL edge cycle %0d: got %h, want %h", i, obs, expect_of(rows[i][11:0]));
      end
      @(posedge clk);
      #1;
    end
    layer_start = 1'b0;
    arr_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_starvation();
    test_full_wrap();
    test_backpressure();
    test_edge_cases();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
